// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings, default widths, FSM states.
package alu_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int OP_W_DEF   = 4;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOT = 4'd5;
   localparam logic [3:0] ALU_SHL = 4'd6;
   localparam logic [3:0] ALU_SHR = 4'd7;
   localparam logic [3:0] ALU_GT  = 4'd8;
   localparam logic [3:0] ALU_EQ  = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Only the arithmetic ops produce a carry worth reporting.
   function automatic logic carry_op(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response signals of the sequencer; master = controller/ALU side, slave = sequencer.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4,
   parameter int NREGS  = 4
);
   localparam int RIDX_W = $clog2(NREGS);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [RIDX_W-1:0] cmd_dst;
   logic [RIDX_W-1:0] cmd_src_a;
   logic [RIDX_W-1:0] cmd_src_b;
   logic              cmd_imm_en;
   logic [DATA_W-1:0] cmd_imm;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_opcode;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_carry;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              rsp_carry;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
      input  cmd_ready,
      input  alu_a, alu_b, alu_opcode,
      output alu_result, alu_zero, alu_carry,
      input  rsp_valid, rsp_result, rsp_zero, rsp_carry,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
      output cmd_ready,
      output alu_a, alu_b, alu_opcode,
      input  alu_result, alu_zero, alu_carry,
      output rsp_valid, rsp_result, rsp_zero, rsp_carry,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// Local register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write port.
module alu_regfile #(
   parameter  int DATA_W = 8,
   parameter  int NREGS  = 4,
   localparam int RIDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RIDX_W-1:0] raddr_a,
   input  logic [RIDX_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [RIDX_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);
   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences register-level ops through an external ALU: IDLE -> ISSUE -> RESP.
// Optional ALU_OP_COUNT_EN adds a 16-bit op_count of completed responses.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int OP_W   = OP_W_DEF,
   parameter  int NREGS  = 4,
   localparam int RIDX_W = $clog2(NREGS)
) (
   input  logic clk,
   input  logic rst_n,
`ifdef ALU_OP_COUNT_EN
   output logic [15:0] op_count,
`endif
   alu_op_sequencer_if.slave bus
);
   state_t            state, state_nx;
   logic [RIDX_W-1:0] dst_q;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic              accept, rsp_fire, wr_en;

   assign accept   = bus.cmd_valid && bus.cmd_ready;
   assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nx = ISSUE;
         ISSUE:   state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      wr_en         = (state == ISSUE);
   end

   alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (bus.cmd_src_a),
      .raddr_b (bus.cmd_src_b),
      .rdata_a (rd_a),
      .rdata_b (rd_b),
      .we      (wr_en),
      .waddr   (dst_q),
      .wdata   (bus.alu_result)
   );

   // Operands are captured at accept; ALU outputs are captured at the end of ISSUE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_opcode <= '0;
         dst_q          <= '0;
         bus.rsp_result <= '0;
         bus.rsp_zero   <= 1'b0;
         bus.rsp_carry  <= 1'b0;
      end else begin
         if (accept) begin
            bus.alu_a      <= rd_a;
            bus.alu_b      <= bus.cmd_imm_en ? bus.cmd_imm : rd_b;
            bus.alu_opcode <= bus.cmd_op;
            dst_q          <= bus.cmd_dst;
         end
         if (wr_en) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp_carry  <= bus.alu_carry && carry_op(4'(bus.alu_opcode));
         end
      end
   end

`ifdef ALU_OP_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)        op_count <= '0;
      else if (rsp_fire) op_count <= op_count + 16'd1;
   end
`else
   logic unused_fire;
   assign unused_fire = rsp_fire;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, reference regfile model and response scoreboard.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int DW = 8;
   localparam int OW = 4;
   localparam int NR = 4;
   localparam int RW = 2;

   typedef struct packed {
      logic [DW-1:0] result;
      logic          zero;
      logic          carry;
   } rsp_t;

   typedef struct packed {
      logic [OW-1:0] op;
      logic [RW-1:0] dst;
      logic [RW-1:0] sa;
      logic [RW-1:0] sb;
      logic          imm_en;
      logic [DW-1:0] imm;
   } cmd_t;

   typedef struct {
      cmd_t cmd;
      rsp_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.DATA_W(DW), .OP_W(OW), .NREGS(NR)) bus ();

`ifdef ALU_OP_COUNT_EN
   logic [15:0] op_count;
   logic [15:0] exp_count;
`endif

   alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .NREGS(NR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef ALU_OP_COUNT_EN
      .op_count (op_count),
`endif
      .bus      (bus)
   );

   // Behavioural ALU; reports a junk carry of 1 for non-arithmetic ops.
   function automatic logic [DW:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
      logic [DW:0] t;
      t = {1'b1, {DW{1'b0}}};
      case (op)
         ALU_ADD: t = {1'b0, a} + {1'b0, b};
         ALU_SUB: t = {1'b0, a} - {1'b0, b};
         ALU_AND: t[DW-1:0] = a & b;
         ALU_OR:  t[DW-1:0] = a | b;
         ALU_XOR: t[DW-1:0] = a ^ b;
         ALU_NOT: t[DW-1:0] = ~a;
         ALU_SHL: t[DW-1:0] = a << 1;
         ALU_SHR: t[DW-1:0] = a >> 1;
         ALU_GT:  t[DW-1:0] = DW'(a > b);
         ALU_EQ:  t[DW-1:0] = DW'(a == b);
         default: t[DW-1:0] = '0;
      endcase
      return t;
   endfunction

   logic [DW:0] alu_env;
   assign alu_env        = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
   assign bus.alu_result = alu_env[DW-1:0];
   assign bus.alu_zero   = (alu_env[DW-1:0] == '0);
   assign bus.alu_carry  = alu_env[DW];

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   rsp_t          sbq[$];
   logic [DW-1:0] ref_rf [NR];
   vec_t          tbl [14];

   function automatic rsp_t model(input cmd_t c);
      rsp_t        r;
      logic [DW-1:0] a, b;
      logic [DW:0] t;
      a = ref_rf[c.sa];
      b = c.imm_en ? c.imm : ref_rf[c.sb];
      t = alu_fn(c.op, a, b);
      r.result = t[DW-1:0];
      r.zero   = (t[DW-1:0] == '0);
      r.carry  = t[DW] && ((c.op == ALU_ADD) || (c.op == ALU_SUB));
      return r;
   endfunction

   function automatic vec_t mk(input logic [OW-1:0] op, input int dst, input int sa, input int sb,
                               input logic ie, input logic [DW-1:0] imm, input logic [DW-1:0] res,
                               input logic z, input logic c);
      vec_t v;
      v.cmd = '{op: op, dst: RW'(dst), sa: RW'(sa), sb: RW'(sb), imm_en: ie, imm: imm};
      v.exp = '{result: res, zero: z, carry: c};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      rsp_t e;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got result %0h expected no response", bus.rsp_result);
         end else begin
            e = sbq.pop_front();
            chk("rsp_result", 32'(bus.rsp_result), 32'(e.result));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
`ifdef ALU_OP_COUNT_EN
            chk("op_count", 32'(op_count), 32'(exp_count));
            exp_count = exp_count + 16'd1;
`endif
         end
      end
   endtask

   task automatic tick(output logic acc);
      @(negedge clk);
      monitor();
      acc = bus.cmd_valid && bus.cmd_ready && rst_n;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send(input cmd_t c, input logic use_exp, input rsp_t texp, output int acc_cyc);
      logic acc;
      rsp_t e;
      bus.cmd_op     = c.op;
      bus.cmd_dst    = c.dst;
      bus.cmd_src_a  = c.sa;
      bus.cmd_src_b  = c.sb;
      bus.cmd_imm_en = c.imm_en;
      bus.cmd_imm    = c.imm;
      bus.cmd_valid  = 1'b1;
      acc     = 1'b0;
      acc_cyc = -1;
      for (int i = 0; i < 40 && !acc; i++) begin
         e = use_exp ? texp : model(c);
         tick(acc);
         if (acc) begin
            sbq.push_back(e);
            ref_rf[c.dst] = e.result;
            acc_cyc = cyc;
         end
      end
      bus.cmd_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
      end
   endtask

   task automatic drain();
      logic a;
      for (int i = 0; i < 20 && sbq.size() > 0; i++) tick(a);
      chk("drain_empty", 32'(sbq.size()), 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) ref_rf[i] = '0;
      sbq.delete();
`ifdef ALU_OP_COUNT_EN
      exp_count = '0;
`endif
   endtask

   initial begin
      logic a;
      int   t0, t1, rel;
      rsp_t e, none;
      cmd_t c;

      none = '0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_src_a = '0;
      bus.cmd_src_b = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b1;
      model_reset();

      tbl[0]  = mk(ALU_ADD, 1, 0, 0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
      tbl[1]  = mk(ALU_ADD, 2, 1, 0, 1'b1, 8'hFF, 8'h04, 1'b0, 1'b1);
      tbl[2]  = mk(ALU_SUB, 3, 1, 1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      tbl[3]  = mk(ALU_GT,  0, 1, 0, 1'b1, 8'h03, 8'h01, 1'b0, 1'b0);
      tbl[4]  = mk(ALU_XOR, 3, 1, 2, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
      tbl[5]  = mk(ALU_AND, 2, 2, 0, 1'b1, 8'h0C, 8'h04, 1'b0, 1'b0);
      tbl[6]  = mk(ALU_OR,  1, 0, 3, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
      tbl[7]  = mk(ALU_NOT, 3, 0, 2, 1'b1, 8'h55, 8'hFE, 1'b0, 1'b0);
      tbl[8]  = mk(ALU_SHL, 2, 3, 0, 1'b1, 8'h00, 8'hFC, 1'b0, 1'b0);
      tbl[9]  = mk(ALU_SHR, 0, 3, 0, 1'b1, 8'h00, 8'h7F, 1'b0, 1'b0);
      tbl[10] = mk(ALU_EQ,  1, 2, 0, 1'b1, 8'hFC, 8'h01, 1'b0, 1'b0);
      tbl[11] = mk(ALU_SUB, 1, 1, 0, 1'b1, 8'h02, 8'hFF, 1'b0, 1'b1);
      tbl[12] = mk(4'hC,    2, 1, 0, 1'b1, 8'h33, 8'h00, 1'b1, 1'b0);
      tbl[13] = mk(ALU_ADD, 0, 0, 0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0);

      rst_n = 1'b0;
      tick(a);
      tick(a);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
      chk("reset_alu_a", 32'(bus.alu_a), 32'd0);
      chk("reset_alu_opcode", 32'(bus.alu_opcode), 32'd0);
`ifdef ALU_OP_COUNT_EN
      chk("reset_op_count", 32'(op_count), 32'd0);
`endif
      @(posedge clk);
      cyc++;
      #1;

      for (int i = 0; i < 14; i++) send(tbl[i].cmd, 1'b1, tbl[i].exp, t0);
      drain();

      // Response stall with a second command waiting.
      bus.rsp_ready = 1'b0;
      c = '{op: ALU_OR, dst: 2'd0, sa: 2'd0, sb: 2'd0, imm_en: 1'b1, imm: 8'h00};
      send(c, 1'b0, none, t0);
      tick(a);
      c = '{op: ALU_ADD, dst: 2'd1, sa: 2'd0, sb: 2'd0, imm_en: 1'b1, imm: 8'h01};
      bus.cmd_op = c.op; bus.cmd_dst = c.dst; bus.cmd_src_a = c.sa; bus.cmd_src_b = c.sb;
      bus.cmd_imm_en = c.imm_en; bus.cmd_imm = c.imm; bus.cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_rsp_result", 32'(bus.rsp_result), 32'hFE);
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         @(posedge clk);
         cyc++;
         #1;
      end
      bus.rsp_ready = 1'b1;
      rel = cyc;
      send(c, 1'b1, '{result: 8'hFF, zero: 1'b0, carry: 1'b0}, t0);
      chk("hold_release_accept", 32'(t0 - rel), 32'd2);
      drain();

      // Back-to-back random ops, then read every register back.
      t1 = -1;
      for (int i = 0; i < 6 + NR; i++) begin
         if (i < 6) begin
            c.op = OW'($urandom_range(15)); c.dst = RW'($urandom_range(NR-1));
            c.sa = RW'($urandom_range(NR-1)); c.sb = RW'($urandom_range(NR-1));
            c.imm_en = 1'($urandom_range(1)); c.imm = DW'($urandom_range(255));
         end else begin
            c = '{op: ALU_OR, dst: RW'(i-6), sa: RW'(i-6), sb: 2'd0, imm_en: 1'b1, imm: 8'h00};
         end
         send(c, 1'b0, none, t0);
         if (t1 >= 0) chk("b2b_spacing", 32'(t0 - t1), 32'd3);
         t1 = t0;
      end
      drain();

      // Reset during ISSUE of a write to r2.
      c = '{op: ALU_ADD, dst: 2'd2, sa: 2'd0, sb: 2'd0, imm_en: 1'b1, imm: 8'h01};
      send(c, 1'b0, none, t0);
      rst_n = 1'b0;
      void'(sbq.pop_back());
      @(posedge clk);
      cyc++;
      #1;
      @(negedge clk);
      chk("rst_issue_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_issue_rsp_result", 32'(bus.rsp_result), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         @(posedge clk);
         cyc++;
         #1;
      end
      c = '{op: ALU_OR, dst: 2'd2, sa: 2'd2, sb: 2'd0, imm_en: 1'b1, imm: 8'h00};
      send(c, 1'b1, '{result: 8'h00, zero: 1'b1, carry: 1'b0}, t0);
      c = '{op: 4'hC, dst: 2'd3, sa: 2'd0, sb: 2'd1, imm_en: 1'b0, imm: 8'h00};
      send(c, 1'b1, '{result: 8'h00, zero: 1'b1, carry: 1'b0}, t0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
